// File: rtl/zswitch_bank.sv
// N-channel switch front end: 2-FF sync, counter debounce, press/release strobes, sticky events.
// Optional long-press strobe enabled by defining ZSWITCH_LONGPRESS_EN.
module zswitch_bank #(
  parameter int NUM_SW          = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1,
  parameter int LONG_CYCLES     = 50000000
) (
  input  logic              iClk,
  input  logic              iRstN,
  input  logic [NUM_SW-1:0] iSw,
  input  logic [NUM_SW-1:0] iEvtClr,
  output logic [NUM_SW-1:0] oSwDown,
  output logic [NUM_SW-1:0] oSwUp,
  output logic [NUM_SW-1:0] oSwLevel,
  output logic [NUM_SW-1:0] oEvtPend,
  output logic              oAnyEvt,
  output logic [NUM_SW-1:0] oSwLong
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [NUM_SW-1:0] RELEASED_PINS = (ACTIVE_LOW != 0) ? {NUM_SW{1'b1}} : {NUM_SW{1'b0}};

  logic [NUM_SW-1:0] r_s1;
  logic [NUM_SW-1:0] r_s2;
  logic [NUM_SW-1:0] w_pressed;
  logic [NUM_SW-1:0] w_accept;
  logic [CNT_W-1:0]  r_cnt [NUM_SW];
  logic [NUM_SW-1:0] r_stable;
  logic [NUM_SW-1:0] r_down;
  logic [NUM_SW-1:0] r_up;
  logic [NUM_SW-1:0] r_evt;
  logic [NUM_SW-1:0] w_evt_next;
  logic              r_any;

  // Sync chain resets to the released pin level so a held switch still yields a press.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_s1 <= RELEASED_PINS;
      r_s2 <= RELEASED_PINS;
    end else begin
      r_s1 <= iSw;
      r_s2 <= r_s1;
    end
  end

  assign w_pressed = (ACTIVE_LOW != 0) ? ~r_s2 : r_s2;

  always_comb begin
    w_accept = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      w_accept[i] = (w_pressed[i] != r_stable[i]) && (r_cnt[i] == DEB_LAST);
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      for (int i = 0; i < NUM_SW; i++) begin
        r_cnt[i] <= '0;
      end
      r_stable <= '0;
      r_down   <= '0;
      r_up     <= '0;
    end else begin
      for (int i = 0; i < NUM_SW; i++) begin
        if ((w_pressed[i] == r_stable[i]) || w_accept[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
      r_stable <= (r_stable & ~w_accept) | (w_pressed & w_accept);
      r_down   <= w_accept & w_pressed;
      r_up     <= w_accept & ~w_pressed;
    end
  end

  // A press strobe in the same cycle as a clear keeps the event pending.
  assign w_evt_next = (r_evt & ~iEvtClr) | r_down;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_evt <= '0;
      r_any <= 1'b0;
    end else begin
      r_evt <= w_evt_next;
      r_any <= |w_evt_next;
    end
  end

  assign oSwDown  = r_down;
  assign oSwUp    = r_up;
  assign oSwLevel = r_stable;
  assign oEvtPend = r_evt;
  assign oAnyEvt  = r_any;

`ifdef ZSWITCH_LONGPRESS_EN
  localparam int               HOLD_W    = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic [HOLD_W-1:0] r_hold [NUM_SW];
  logic [NUM_SW-1:0] r_long;

  // Hold counter saturates, so the long strobe fires once per press.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      for (int i = 0; i < NUM_SW; i++) begin
        r_hold[i] <= '0;
      end
      r_long <= '0;
    end else begin
      for (int i = 0; i < NUM_SW; i++) begin
        if (!r_stable[i]) begin
          r_hold[i] <= '0;
        end else if (r_hold[i] != HOLD_MAX) begin
          r_hold[i] <= r_hold[i] + 1'b1;
        end
        r_long[i] <= r_stable[i] && (r_hold[i] == HOLD_LAST);
      end
    end
  end

  assign oSwLong = r_long;
`else
  logic w_unused_long;
  assign w_unused_long = (LONG_CYCLES > 0);
  assign oSwLong       = '0;
`endif

endmodule

// File: tb/tb_zswitch_bank.sv
// Directed-vector bench for zswitch_bank (NUM_SW=4, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, LONG_CYCLES=20).
// Long-press expectations follow ZSWITCH_LONGPRESS_EN.
module tb_zswitch_bank;

  logic       iClk;
  logic       iRstN;
  logic [3:0] iSw;
  logic [3:0] iEvtClr;
  logic [3:0] oSwDown;
  logic [3:0] oSwUp;
  logic [3:0] oSwLevel;
  logic [3:0] oEvtPend;
  logic       oAnyEvt;
  logic [3:0] oSwLong;

  int vectors;
  int miscompares;

  zswitch_bank #(
    .NUM_SW(4),
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW(1),
    .LONG_CYCLES(20)
  ) dut (
    .iClk(iClk),
    .iRstN(iRstN),
    .iSw(iSw),
    .iEvtClr(iEvtClr),
    .oSwDown(oSwDown),
    .oSwUp(oSwUp),
    .oSwLevel(oSwLevel),
    .oEvtPend(oEvtPend),
    .oAnyEvt(oAnyEvt),
    .oSwLong(oSwLong)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Advance past the next rising edge; inputs driven here are sampled at the following edge.
  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic test_reset();
    logic [20:0] got;
    iRstN   = 1'b0;
    iSw     = 4'hF;
    iEvtClr = 4'h0;
    repeat (3) tick();
    got = {oSwDown, oSwUp, oSwLevel, oEvtPend, oAnyEvt, oSwLong};
    vectors++;
    if (got !== 21'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_held: got %h expected %h", got, 21'h0);
    end
    iRstN = 1'b1;
    for (int c = 0; c < 100; c++) begin
      tick();
      got = {oSwDown, oSwUp, oSwLevel, oEvtPend, oAnyEvt, oSwLong};
      vectors++;
      if (got !== 21'h0) begin
        miscompares++;
        $display("[TB] FAIL reset_idle cycle %0d: got %h expected %h", c, got, 21'h0);
      end
    end
  endtask

  task automatic test_clean_press();
    iSw = 4'b1110;
    repeat (5) tick();
    vectors++;
    if (oSwDown !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL press_early: oSwDown got %b expected %b", oSwDown, 4'b0000);
    end
    tick();
    vectors++;
    if ({oSwDown, oSwLevel, oEvtPend} !== {4'b0001, 4'b0001, 4'b0000}) begin
      miscompares++;
      $display("[TB] FAIL press_strobe: down/level/pend got %b/%b/%b expected 0001/0001/0000",
               oSwDown, oSwLevel, oEvtPend);
    end
    tick();
    vectors++;
    if ({oSwDown, oEvtPend, oAnyEvt} !== {4'b0000, 4'b0001, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL press_sticky: down/pend/any got %b/%b/%b expected 0000/0001/1",
               oSwDown, oEvtPend, oAnyEvt);
    end
    iSw = 4'hF;
    repeat (5) tick();
    vectors++;
    if (oSwUp !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL release_early: oSwUp got %b expected %b", oSwUp, 4'b0000);
    end
    tick();
    vectors++;
    if ({oSwUp, oSwLevel} !== {4'b0001, 4'b0000}) begin
      miscompares++;
      $display("[TB] FAIL release_strobe: up/level got %b/%b expected 0001/0000", oSwUp, oSwLevel);
    end
    tick();
    vectors++;
    if ({oSwUp, oEvtPend, oAnyEvt} !== {4'b0000, 4'b0001, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL release_after: up/pend/any got %b/%b/%b expected 0000/0001/1",
               oSwUp, oEvtPend, oAnyEvt);
    end
    iEvtClr = 4'b0001;
    tick();
    iEvtClr = 4'b0000;
    vectors++;
    if ({oEvtPend, oAnyEvt} !== {4'b0000, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL clear_ch0: pend/any got %b/%b expected 0000/0", oEvtPend, oAnyEvt);
    end
  endtask

  task automatic test_bounce();
    logic [3:0] pattern [8];
    pattern = '{4'b1101, 4'b1101, 4'b1101, 4'b1111, 4'b1101, 4'b1101, 4'b1101, 4'b1111};
    for (int k = 0; k < 8; k++) begin
      iSw = pattern[k];
      tick();
      vectors++;
      if ({oSwDown, oSwUp, oSwLevel} !== 12'h000) begin
        miscompares++;
        $display("[TB] FAIL bounce step %0d: down/up/level got %b/%b/%b expected 0000/0000/0000",
                 k, oSwDown, oSwUp, oSwLevel);
      end
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      vectors++;
      if ({oSwDown, oSwUp, oSwLevel, oEvtPend} !== 16'h0000) begin
        miscompares++;
        $display("[TB] FAIL bounce_settle %0d: down/up/level/pend got %b/%b/%b/%b expected all 0",
                 k, oSwDown, oSwUp, oSwLevel, oEvtPend);
      end
    end
  endtask

  task automatic test_clear_race();
    iSw = 4'b1011;
    repeat (5) tick();
    iEvtClr = 4'b0100;
    tick();
    vectors++;
    if ({oSwDown, oEvtPend} !== {4'b0100, 4'b0000}) begin
      miscompares++;
      $display("[TB] FAIL race_strobe: down/pend got %b/%b expected 0100/0000", oSwDown, oEvtPend);
    end
    tick();
    iEvtClr = 4'b0000;
    vectors++;
    if ({oEvtPend, oAnyEvt} !== {4'b0100, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL race_set_wins: pend/any got %b/%b expected 0100/1", oEvtPend, oAnyEvt);
    end
    iSw = 4'hF;
    repeat (8) tick();
    vectors++;
    if ({oEvtPend, oSwLevel} !== {4'b0100, 4'b0000}) begin
      miscompares++;
      $display("[TB] FAIL race_hold: pend/level got %b/%b expected 0100/0000", oEvtPend, oSwLevel);
    end
    iEvtClr = 4'b0100;
    tick();
    iEvtClr = 4'b0000;
    vectors++;
    if ({oEvtPend, oAnyEvt} !== {4'b0000, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL race_clear: pend/any got %b/%b expected 0000/0", oEvtPend, oAnyEvt);
    end
  endtask

  task automatic test_multi_channel();
    iSw = 4'h0;
    repeat (6) tick();
    vectors++;
    if ({oSwDown, oSwLevel} !== {4'hF, 4'hF}) begin
      miscompares++;
      $display("[TB] FAIL multi_down: down/level got %h/%h expected F/F", oSwDown, oSwLevel);
    end
    tick();
    vectors++;
    if ({oSwDown, oEvtPend, oAnyEvt} !== {4'h0, 4'hF, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL multi_pend: down/pend/any got %h/%h/%b expected 0/F/1",
               oSwDown, oEvtPend, oAnyEvt);
    end
    iSw = 4'hF;
    repeat (6) tick();
    vectors++;
    if ({oSwUp, oSwLevel} !== {4'hF, 4'h0}) begin
      miscompares++;
      $display("[TB] FAIL multi_up: up/level got %h/%h expected F/0", oSwUp, oSwLevel);
    end
    iEvtClr = 4'hF;
    tick();
    iEvtClr = 4'h0;
    vectors++;
    if ({oEvtPend, oAnyEvt} !== {4'h0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL multi_clear: pend/any got %h/%b expected 0/0", oEvtPend, oAnyEvt);
    end
  endtask

  task automatic test_reset_mid_debounce();
    logic [20:0] got;
    iSw = 4'b0111;
    repeat (3) tick();
    iRstN = 1'b0;
    repeat (4) tick();
    got = {oSwDown, oSwUp, oSwLevel, oEvtPend, oAnyEvt, oSwLong};
    vectors++;
    if (got !== 21'h0) begin
      miscompares++;
      $display("[TB] FAIL midreset_held: got %h expected %h", got, 21'h0);
    end
    iRstN = 1'b1;
    repeat (5) tick();
    vectors++;
    if ({oSwDown, oSwLevel} !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL midreset_early: down/level got %b/%b expected 0000/0000", oSwDown, oSwLevel);
    end
    tick();
    vectors++;
    if ({oSwDown, oSwLevel} !== {4'b1000, 4'b1000}) begin
      miscompares++;
      $display("[TB] FAIL midreset_redetect: down/level got %b/%b expected 1000/1000",
               oSwDown, oSwLevel);
    end
    iSw = 4'hF;
    repeat (8) tick();
    iEvtClr = 4'hF;
    tick();
    iEvtClr = 4'h0;
    vectors++;
    if ({oSwLevel, oEvtPend, oAnyEvt} !== 9'h000) begin
      miscompares++;
      $display("[TB] FAIL midreset_cleanup: level/pend/any got %b/%b/%b expected 0000/0000/0",
               oSwLevel, oEvtPend, oAnyEvt);
    end
  endtask

  task automatic test_long_press();
    logic [3:0] expLong;
    iSw = 4'b0111;
    for (int t = 1; t <= 40; t++) begin
      tick();
`ifdef ZSWITCH_LONGPRESS_EN
      expLong = (t == 26) ? 4'b1000 : 4'b0000;
`else
      expLong = 4'b0000;
`endif
      vectors++;
      if (oSwLong !== expLong) begin
        miscompares++;
        $display("[TB] FAIL long_hold t=%0d: oSwLong got %b expected %b", t, oSwLong, expLong);
      end
      if (t == 6) begin
        vectors++;
        if (oSwDown !== 4'b1000) begin
          miscompares++;
          $display("[TB] FAIL long_down: oSwDown got %b expected %b", oSwDown, 4'b1000);
        end
      end
    end
    iSw = 4'hF;
    for (int t = 0; t < 10; t++) begin
      tick();
      vectors++;
      if (oSwLong !== 4'b0000) begin
        miscompares++;
        $display("[TB] FAIL long_release t=%0d: oSwLong got %b expected 0000", t, oSwLong);
      end
    end
    iSw = 4'b0111;
    for (int t = 0; t < 40; t++) begin
      if (t == 10) iSw = 4'hF;
      tick();
      vectors++;
      if (oSwLong !== 4'b0000) begin
        miscompares++;
        $display("[TB] FAIL short_hold t=%0d: oSwLong got %b expected 0000", t, oSwLong);
      end
    end
    vectors++;
    if (oSwLevel !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL short_hold_level: oSwLevel got %b expected 0000", oSwLevel);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    iRstN       = 1'b0;
    iSw         = 4'hF;
    iEvtClr     = 4'h0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_clear_race();
    test_multi_channel();
    test_reset_mid_debounce();
    test_long_press();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
